// File: rtl/dram_req_queue_if.sv
// Request/head bundle between the request generator (master) and the DRAM request queue (slave).
// Widths follow the queue parameters so both sides agree on COUNT and strobe sizes.
interface dram_req_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int STRB_W = DATA_W / 8;

    logic              PUSH;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WRITE_DATA;
    logic [STRB_W-1:0] WSTRB;
    logic              R_W;
    logic              POP;
    logic              CLEAR_ERR;

    logic [ADDR_W-1:0] ADDRESS_OUT;
    logic [DATA_W-1:0] WRITE_DATA_OUT;
    logic [STRB_W-1:0] WSTRB_OUT;
    logic              R_W_OUT;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic [CNT_W-1:0]  COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output PUSH, ADDRESS, WRITE_DATA, WSTRB, R_W, POP, CLEAR_ERR,
        input  ADDRESS_OUT, WRITE_DATA_OUT, WSTRB_OUT, R_W_OUT,
        input  EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, ADDRESS, WRITE_DATA, WSTRB, R_W, POP, CLEAR_ERR,
        output ADDRESS_OUT, WRITE_DATA_OUT, WSTRB_OUT, R_W_OUT,
        output EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/dram_req_queue.sv
// In-order DRAM request queue with show-ahead head, occupancy count, almost-full margin
// and sticky overflow/underflow flags; a push at capacity is accepted when paired with a pop.
module dram_req_queue #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int AF_MARGIN = 1
) (
    input logic             CLK,
    input logic             RESET,
    dram_req_queue_if.slave bus
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = CNT_W - 1;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              r_w;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t           storage [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             overflow_q;
    logic             underflow_q;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic             head_valid;
    entry_t           head;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = bus.PUSH & (~full | bus.POP);
    assign pop_ok  = bus.POP & ~empty;

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; only pointers and flags define validity, so stale data is never exposed.
    always_ff @(posedge CLK) begin
        if (!RESET && push_ok) begin
            storage[wr_ptr[IDX_W-1:0]] <= '{r_w:   bus.R_W,
                                            wstrb: bus.WSTRB,
                                            data:  bus.WRITE_DATA,
                                            addr:  bus.ADDRESS};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + CNT_W'(1);
            count <= count_next;

            // A new error in the same cycle as CLEAR_ERR keeps the flag set.
            if (bus.PUSH && full && !bus.POP) overflow_q <= 1'b1;
            else if (bus.CLEAR_ERR)           overflow_q <= 1'b0;

            if (bus.POP && empty)             underflow_q <= 1'b1;
            else if (bus.CLEAR_ERR)           underflow_q <= 1'b0;
        end
    end

    // Pointers differ (including wrap bit) exactly when the queue holds data, matching !EMPTY.
    assign head_valid = (wr_ptr != rd_ptr);
    assign head       = head_valid ? storage[rd_ptr[IDX_W-1:0]] : '0;

    assign bus.ADDRESS_OUT    = head.addr;
    assign bus.WRITE_DATA_OUT = head.data;
    assign bus.WSTRB_OUT      = head.wstrb;
    assign bus.R_W_OUT        = head.r_w;
    assign bus.EMPTY          = empty;
    assign bus.FULL           = full;
    assign bus.ALMOST_FULL    = (count >= CNT_W'(DEPTH - AF_MARGIN));
    assign bus.COUNT          = count;
    assign bus.OVERFLOW       = overflow_q;
    assign bus.UNDERFLOW      = underflow_q;
endmodule
